// File: rtl/slice_loader.sv
// slice_loader
// Input-side stage of the matrix encoder. Deserialises a 1-bit, MSB-first
// input stream into N-bit slices and hands them, one at a time, to the
// encoder datapath over a valid/ready handshake. A frame is S slices whose
// indices count down from S-1 to 0, matching the encoder's slice counter.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-low reset
//   start        one-cycle frame request, honoured only in IDLE
//   bit_in       serial data, first bit becomes slice bit N-1
//   bit_valid    bit_in is valid this cycle
//   bit_ready    loader accepts a bit this cycle
//   slice_out    held slice
//   slice_idx    index of the slice on slice_out (S-1 down to 0)
//   slice_valid  slice_out / slice_idx are valid
//   slice_ready  downstream accepts the slice
//   busy         frame in progress
//   done         one-cycle pulse after the last slice is accepted
module slice_loader #(
  parameter int N  = 25,
  parameter int S  = 64,
  parameter int IW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          bit_in,
  input  logic          bit_valid,
  output logic          bit_ready,
  output logic [N-1:0]  slice_out,
  output logic [IW-1:0] slice_idx,
  output logic          slice_valid,
  input  logic          slice_ready,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] BitsFull = CW'(N);
  localparam logic [CW-1:0] BitsLast = CW'(N - 1);
  localparam logic [IW:0]   LoadMax  = (IW + 1)'(S);
  localparam logic [IW-1:0] IdxTop   = IW'(S - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e        state_q;
  logic [N-1:0]  sh_q;
  logic [CW-1:0] bitCnt_q;
  logic [N-1:0]  hold_q;
  logic          holdFull_q;
  logic [IW:0]   loaded_q;
  logic [IW-1:0] idx_q;

  logic          bitTake;
  logic          sliceTake;
  logic          sliceComplete;
  logic          transfer;
  logic [N-1:0]  shNext_d;
  logic [N-1:0]  completed_d;

  // A parked full slice (bitCnt_q == N) blocks further bits until the hold
  // register frees up; no bits at all once the whole frame has been loaded.
  assign bit_ready   = (state_q == StRun) && (loaded_q < LoadMax) && (bitCnt_q != BitsFull);
  assign slice_valid = holdFull_q;
  assign slice_out   = hold_q;
  assign slice_idx   = idx_q;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);

  // A slice is complete either because its last bit lands this cycle or
  // because it has been parked in sh_q waiting for the hold register. The
  // move into hold may ride on the same edge as the downstream handshake,
  // which keeps slice_valid high without a bubble after a stall.
  always_comb begin
    bitTake       = bit_valid && bit_ready;
    sliceTake     = holdFull_q && slice_ready;
    shNext_d      = {sh_q[N-2:0], bit_in};
    sliceComplete = (bitTake && (bitCnt_q == BitsLast)) || (bitCnt_q == BitsFull);
    completed_d   = (bitCnt_q == BitsFull) ? sh_q : shNext_d;
    transfer      = (state_q == StRun) && sliceComplete && (!holdFull_q || sliceTake);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      sh_q       <= '0;
      bitCnt_q   <= '0;
      hold_q     <= '0;
      holdFull_q <= 1'b0;
      loaded_q   <= '0;
      idx_q      <= IdxTop;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StRun;
            bitCnt_q <= '0;
            loaded_q <= '0;
            idx_q    <= IdxTop;
          end
        end

        StRun: begin
          if (bitTake) begin
            sh_q <= shNext_d;
          end

          if (transfer) begin
            hold_q     <= completed_d;
            holdFull_q <= 1'b1;
            bitCnt_q   <= '0;
            loaded_q   <= loaded_q + 1'b1;
          end else if (bitTake) begin
            bitCnt_q <= bitCnt_q + 1'b1;
          end

          // The index-0 handshake can never coincide with a transfer because
          // every slice of the frame has already been loaded by then.
          if (sliceTake) begin
            if (idx_q == '0) begin
              state_q    <= StDone;
              holdFull_q <= 1'b0;
            end else begin
              idx_q <= idx_q - 1'b1;
              if (!transfer) begin
                holdFull_q <= 1'b0;
              end
            end
          end
        end

        StDone: begin
          bitCnt_q <= '0;
          loaded_q <= '0;
          idx_q    <= IdxTop;
          state_q  <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slice_loader.sv
// tb_slice_loader
// Directed self-checking bench for slice_loader. Inputs are driven and
// outputs sampled on the falling edge, away from the active rising edge.
module tb_slice_loader;

  localparam int N  = 25;
  localparam int S  = 64;
  localparam int IW = 6;
  localparam int FrameBits = S * N;

  logic          clk;
  logic          rst;
  logic          start;
  logic          bit_in;
  logic          bit_valid;
  logic          bit_ready;
  logic [N-1:0]  slice_out;
  logic [IW-1:0] slice_idx;
  logic          slice_valid;
  logic          slice_ready;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  slice_loader #(.N(N), .S(S), .IW(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .slice_out   (slice_out),
    .slice_idx   (slice_idx),
    .slice_valid (slice_valid),
    .slice_ready (slice_ready),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slice k of the test frame is 25'h1555555 ^ k, sent MSB first.
  function automatic logic [N-1:0] expSlice(input int k);
    return 25'h1555555 ^ 25'(k);
  endfunction

  function automatic logic expBit(input int j);
    logic [N-1:0] s;
    s = expSlice(j / N);
    return s[N - 1 - (j % N)];
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    slice_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bit_ready !== 1'b0 || slice_out !== '0 || slice_idx !== 6'd63 ||
          slice_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_values got rdy=%b out=%h idx=%0d v=%b busy=%b done=%b exp 0 0 63 0 0 0",
                 bit_ready, slice_out, slice_idx, slice_valid, busy, done);
      end
    end
    rst = 1'b1;
    start = 1'b0;
    bit_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bit_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got busy=%b rdy=%b exp 0 0", busy, bit_ready);
    end
  endtask

  // Streams a whole frame with slice_ready held high. gapped randomises
  // bit_valid; pokeStart pulses start mid-run and again in the DONE cycle.
  task automatic test_full_frame(input bit gapped, input bit pokeStart, input string tag);
    int  bitIdx;
    int  sliceCnt;
    int  edgeCnt;
    int  doneEdge;
    bit  completeNext;
    bitIdx = 0;
    sliceCnt = 0;
    doneEdge = -1;
    completeNext = 1'b0;
    slice_ready = 1'b1;
    bit_valid = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edgeCnt = 0;
    checks++;
    if (busy !== 1'b1 || bit_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s start_response got busy=%b rdy=%b exp 1 1", tag, busy, bit_ready);
    end
    while (edgeCnt < 4000) begin
      checks++;
      if (slice_valid !== completeNext) begin
        errors++;
        $display("[TB] FAIL %s valid_timing edge=%0d got %b exp %b", tag, edgeCnt, slice_valid, completeNext);
      end
      if (slice_valid === 1'b1) begin
        checks++;
        if (slice_out !== expSlice(sliceCnt) || slice_idx !== 6'(63 - sliceCnt)) begin
          errors++;
          $display("[TB] FAIL %s slice_data k=%0d got %h/%0d exp %h/%0d", tag, sliceCnt,
                   slice_out, slice_idx, expSlice(sliceCnt), 63 - sliceCnt);
        end
        sliceCnt++;
      end
      if (done === 1'b1) begin
        doneEdge = edgeCnt;
        break;
      end
      if (bitIdx >= FrameBits) begin
        checks++;
        if (bit_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL %s excess_bit_ready edge=%0d got %b exp 0", tag, edgeCnt, bit_ready);
        end
      end
      bit_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      bit_in = (bitIdx < FrameBits) ? expBit(bitIdx) : 1'($urandom_range(0, 1));
      start = pokeStart && (edgeCnt == 100);
      completeNext = 1'b0;
      if (bit_valid && bit_ready) begin
        bitIdx++;
        completeNext = ((bitIdx % N) == 0);
      end
      @(negedge clk);
      edgeCnt++;
    end
    checks++;
    if (doneEdge < 0) begin
      errors++;
      $display("[TB] FAIL %s done_timeout got no done exp done within 4000 cycles", tag);
    end else if (!gapped && doneEdge != 1 + FrameBits) begin
      errors++;
      $display("[TB] FAIL %s done_edge got %0d exp %0d", tag, doneEdge, 1 + FrameBits);
    end
    checks++;
    if (sliceCnt != S || bitIdx != FrameBits || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s frame_totals got slices=%0d bits=%0d busy=%b exp %0d %0d 1",
               tag, sliceCnt, bitIdx, busy, S, FrameBits);
    end
    start = pokeStart;
    bit_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || bit_ready !== 1'b0 ||
          slice_valid !== 1'b0 || slice_idx !== 6'd63) begin
        errors++;
        $display("[TB] FAIL %s after_done got busy=%b done=%b rdy=%b v=%b idx=%0d exp 0 0 0 0 63",
                 tag, busy, done, bit_ready, slice_valid, slice_idx);
      end
      @(negedge clk);
    end
    bit_valid = 1'b0;
  endtask

  task automatic test_back_to_back_frame();
    test_full_frame(1'b0, 1'b0, "nostall");
  endtask

  task automatic test_backpressure();
    int bitIdx;
    int waitCnt;
    bitIdx = 0;
    slice_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitCnt = 0;
    while (slice_valid !== 1'b1 && waitCnt < 100) begin
      bit_valid = 1'b1;
      bit_in = expBit(bitIdx);
      if (bit_ready) bitIdx++;
      @(negedge clk);
      waitCnt++;
    end
    checks++;
    if (slice_valid !== 1'b1 || bitIdx != N) begin
      errors++;
      $display("[TB] FAIL bp_first_slice got v=%b bits=%0d exp 1 %0d", slice_valid, bitIdx, N);
    end
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (slice_valid !== 1'b1 || slice_out !== expSlice(0) || slice_idx !== 6'd63) begin
        errors++;
        $display("[TB] FAIL bp_stable cyc=%0d got v=%b %h/%0d exp 1 %h/63",
                 i, slice_valid, slice_out, slice_idx, expSlice(0));
      end
      bit_valid = 1'b1;
      bit_in = expBit(bitIdx);
      if (bit_ready) bitIdx++;
      @(negedge clk);
    end
    checks++;
    if (bitIdx != 2 * N || bit_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_bit_limit got bits=%0d rdy=%b exp %0d 0", bitIdx, bit_ready, 2 * N);
    end
    slice_ready = 1'b1;
    @(negedge clk);
    slice_ready = 1'b0;
    bit_valid = 1'b0;
    checks++;
    if (slice_valid !== 1'b1 || slice_out !== expSlice(1) || slice_idx !== 6'd62 || bit_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release got v=%b %h/%0d rdy=%b exp 1 %h/62 1",
               slice_valid, slice_out, slice_idx, bit_ready, expSlice(1));
    end
  endtask

  task automatic test_reset_mid_frame();
    int bitIdx;
    bitIdx = 0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    slice_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bit_valid = 1'b1;
      bit_in = expBit(bitIdx);
      if (bit_ready) bitIdx++;
      @(negedge clk);
    end
    checks++;
    if (bitIdx != 30 || slice_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_hold_full got bits=%0d v=%b exp 30 1", bitIdx, slice_valid);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (slice_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 ||
          bit_ready !== 1'b0 || slice_out !== '0 || slice_idx !== 6'd63) begin
        errors++;
        $display("[TB] FAIL mid_reset got v=%b done=%b busy=%b rdy=%b out=%h idx=%0d exp 0 0 0 0 0 63",
                 slice_valid, done, busy, bit_ready, slice_out, slice_idx);
      end
    end
    rst = 1'b1;
    bit_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_release got done=%b busy=%b exp 0 0", done, busy);
    end
    test_full_frame(1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_gapped_input();
    test_full_frame(1'b1, 1'b0, "gapped");
  endtask

  task automatic test_ignored_start();
    test_full_frame(1'b0, 1'b1, "ignored_start");
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    bit_in = 1'b0;
    bit_valid = 1'b0;
    slice_ready = 1'b0;
    test_reset();
    test_back_to_back_frame();
    test_backpressure();
    test_reset_mid_frame();
    test_gapped_input();
    test_ignored_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slice_loader.md
# slice_loader

Input-side stage of the matrix encoder. It deserialises a 1-bit input stream into 25-bit slices and presents them one at a time to the encoder datapath through a valid/ready handshake. A frame is 64 slices. Slices are indexed from 63 down to 0, matching the encoder's down-counting slice counter, which resets to 63.

## Interface
Parameters:
- N, 25, slice width in bits (5x5 matrix)
- S, 64, slices per frame
- IW, 6, slice index width; must satisfy 2^IW >= S

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE
- bit_in  in  1  serial data; the first bit received becomes slice bit N-1 (MSB first)
- bit_valid  in  1  bit_in is valid this cycle
- bit_ready  out  1  loader accepts a bit this cycle
- slice_out  out  N  held slice
- slice_idx  out  IW  index of the slice on slice_out; counts S-1 down to 0
- slice_valid  out  1  slice_out and slice_idx are valid
- slice_ready  in  1  downstream accepts the slice
- busy  out  1  frame in progress (state != IDLE)
- done  out  1  one-cycle pulse after the last slice is accepted

## Operation
- **Bit handshake:** a bit is taken when bit_valid && bit_ready.
- **Slice handshake:** a slice is taken when slice_valid && slice_ready.
- **Storage:** a shift register (sh, N bits), a bit counter (0..N), a hold register (hold, N bits, with a hold_full flag), a loaded-slice counter (0..S) and an emitted index (slice_idx).
- **States:**
  - IDLE: bit_ready=0, slice_valid=0. If start=1, go to RUN, clear the bit and loaded counters, and set slice_idx=S-1.
  - RUN:
    - bit_ready = (loaded < S) && !(bit_cnt == N).
    - An accepted bit performs sh <= {sh[N-2:0], bit_in} and bit_cnt+1.
  - DONE: done=1 for exactly one cycle. All counters clear, slice_idx returns to S-1, and the block goes to IDLE.
- **Transfer sh -> hold:**
  - Occurs when a complete slice exists, either because the Nth bit is accepted this cycle or because bit_cnt==N.
  - Requires that hold is empty or is being handed off this cycle.
  - On transfer, hold <= completed slice, hold_full=1, bit_cnt=0, loaded+1.
  - If the Nth bit arrives while hold is full and not draining, sh keeps the slice and bit_cnt=N, which holds bit_ready=0. The transfer happens in the cycle the hold handshake occurs, so slice_valid stays high with no bubble.
- **Slice handshake, not last:** hold_full clears unless a transfer happens the same cycle, and slice_idx decrements.
- **Slice handshake with slice_idx==0:** go to DONE.
- **Output relations:** slice_valid = hold_full and slice_out = hold.
- **Ignored inputs:**
  - start while busy.
  - bit_in when bit_ready=0, even if bit_valid=1.
- **Bits after the 64th slice:** refused, because bit_ready=0 once loaded==S.
- **Reset:** rst=0 at any edge forces IDLE. Everything is cleared, including a partial slice or an unaccepted held slice. No done pulse is produced.

## Timing
- **Reset values:** bit_ready=0, slice_out=0, slice_idx=S-1 (63), slice_valid=0, busy=0, done=0.
- **Start:** start sampled at edge t gives busy=1 and bit_ready=1 from t+1.
- **Slice latency:** Nth bit accepted at edge t with hold free gives slice_valid=1 from t+1.
- **Throughput:** with bit_valid and slice_ready held at 1, a frame is 1 start cycle + S*N bit cycles.
  - slice_valid is high for one cycle per slice.
  - Slice k (k=0..S-1) is presented on the cycle after the bit that completes it.
  - slice_idx on slice k is S-1-k.
- **Stall:** while slice_valid=1 && slice_ready=0, slice_out and slice_idx stay stable. At most N more bits are accepted before bit_ready drops.
- **Release after stall:** when the hold handshake occurs with bit_cnt==N, the new slice appears at the next edge and bit_ready rises at that same edge.
- **Completion:** last slice handshake at edge t gives done=1 and busy=1 during cycle t+1. At t+2, busy=0, done=0, state IDLE.
- **start in the DONE cycle:** ignored.

## Test plan
- **Reset:** assert rst=0 for 2 cycles mid-stream -> all outputs at reset values, slice_idx=63, and a following frame starts cleanly.
- **Full frame, no stalls:** feed pattern bits where slice k = 25'h1555555 ^ k, MSB first, with slice_ready=1 -> 64 slices with matching data and idx 63..0 in order, done at cycle 1+1600+1, busy low the cycle after.
- **Backpressure:** hold slice_ready=0 after the first slice -> exactly 25 further bits accepted, then bit_ready=0. slice_out stays fixed. Releasing ready gives the second slice on the next cycle with no gap in slice_valid.
- **Gapped input:** toggle bit_valid at random 50% -> same slice data as the no-stall frame, and no bits are accepted while bit_ready=0.
- **Reset mid-frame:** rst=0 after 30 bits (hold full) -> slice_valid=0 and no done. A new start followed by 1600 bits yields a correct 64-slice frame.
- **Ignored start and excess bits:** pulse start during RUN, then drive bit_valid=1 past 1600 bits -> no restart, no extra slices, bit_ready=0 after the 1600th bit.
